// File: rtl/reg_wb_arbiter.sv
// Round-robin arbiter sharing the register-file write port between ALU and load writeback.
// Define REG_WB_ARBITER_STATS_EN to add saturating grant/conflict counters.
module reg_wb_arbiter #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 33,
    parameter int CNT_W  = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_hold,
    input  logic              i_req0_valid,
    output logic              o_req0_ready,
    input  logic [ADDR_W-1:0] i_req0_addr,
    input  logic [DATA_W-1:0] i_req0_data,
    input  logic              i_req1_valid,
    output logic              o_req1_ready,
    input  logic [ADDR_W-1:0] i_req1_addr,
    input  logic [DATA_W-1:0] i_req1_data,
    output logic              o_wr_en,
    output logic [ADDR_W-1:0] o_wr_addr,
    output logic [DATA_W-1:0] o_wr_data,
    output logic              o_last_grant
`ifdef REG_WB_ARBITER_STATS_EN
    ,
    output logic [CNT_W-1:0]  o_grant0_cnt,
    output logic [CNT_W-1:0]  o_grant1_cnt,
    output logic [CNT_W-1:0]  o_conflict_cnt
`endif
);

    typedef enum logic {
        P0 = 1'b0,
        P1 = 1'b1
    } rr_t;

    rr_t  r_rr_ptr;
    rr_t  w_rr_nxt;
    logic w_open;
    logic w_gnt0;
    logic w_gnt1;

    // Nothing is granted while in reset or while the controller holds the port
    assign w_open = !i_rst && !i_hold;
    assign w_gnt0 = w_open && i_req0_valid &&
                    (!i_req1_valid || r_rr_ptr == P0);
    assign w_gnt1 = w_open && i_req1_valid &&
                    (!i_req0_valid || r_rr_ptr == P1);

    assign o_req0_ready = w_gnt0;
    assign o_req1_ready = w_gnt1;

    // Round-robin pointer register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rr_ptr <= P0;
        end else begin
            r_rr_ptr <= w_rr_nxt;
        end
    end

    // Priority passes to the requester that was not just served
    always_comb begin
        w_rr_nxt = r_rr_ptr;
        unique case (1'b1)
            w_gnt0:  w_rr_nxt = P1;
            w_gnt1:  w_rr_nxt = P0;
            default: w_rr_nxt = r_rr_ptr;
        endcase
    end

    // Registered write port; address/data hold when idle
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_wr_en      <= 1'b0;
            o_wr_addr    <= '0;
            o_wr_data    <= '0;
            o_last_grant <= 1'b0;
        end else begin
            o_wr_en <= w_gnt0 || w_gnt1;
            if (w_gnt0) begin
                o_wr_addr    <= i_req0_addr;
                o_wr_data    <= i_req0_data;
                o_last_grant <= 1'b0;
            end else if (w_gnt1) begin
                o_wr_addr    <= i_req1_addr;
                o_wr_data    <= i_req1_data;
                o_last_grant <= 1'b1;
            end
        end
    end

`ifdef REG_WB_ARBITER_STATS_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic w_conflict;

    assign w_conflict = !i_hold && i_req0_valid && i_req1_valid;

    // Saturating statistics counters
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_grant0_cnt   <= '0;
            o_grant1_cnt   <= '0;
            o_conflict_cnt <= '0;
        end else begin
            if (w_gnt0 && o_grant0_cnt != CNT_MAX) begin
                o_grant0_cnt <= o_grant0_cnt + CNT_ONE;
            end
            if (w_gnt1 && o_grant1_cnt != CNT_MAX) begin
                o_grant1_cnt <= o_grant1_cnt + CNT_ONE;
            end
            if (w_conflict && o_conflict_cnt != CNT_MAX) begin
                o_conflict_cnt <= o_conflict_cnt + CNT_ONE;
            end
        end
    end
`endif

endmodule
